// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, parity masks and the codeword position map.
// The decoder imports this too, so both sides agree on bit ordering.
package hamming_pkg;

  localparam int unsigned MSG_W = 4;
  localparam int unsigned CW_W  = 7;

  typedef logic [MSG_W-1:0] msg_t;
  typedef logic [CW_W-1:0]  cw_t;

  // Parity masks select the message bits (d1 = bit 0) covered by each parity bit.
  localparam msg_t P1_MASK = 4'b1011;
  localparam msg_t P2_MASK = 4'b1101;
  localparam msg_t P4_MASK = 4'b1110;

  // Codeword bit index of each parity bit (Hamming position minus one).
  localparam int unsigned P1_POS = 0;
  localparam int unsigned P2_POS = 1;
  localparam int unsigned P4_POS = 3;

  // Codeword bit index of d1..d4.
  localparam int unsigned DATA_POS [MSG_W] = '{2, 4, 5, 6};

endpackage

// File: rtl/hamming74_parity.sv
// Combinational Hamming(7,4) word builder: places data bits and computes parity.
// Reusable by the decoder for syndrome generation.
module hamming74_parity
  import hamming_pkg::*;
(
  input  logic [MSG_W-1:0] message,
  output logic [CW_W-1:0]  code
);

  always_comb begin
    // NOTE: every bit gets a default before the conditional writes, so no latch is inferred.
    code = '0;
    for (int i = 0; i < int'(MSG_W); i++) begin
      code[DATA_POS[i]] = message[i];
    end
    code[P1_POS] = ^(message & P1_MASK);
    code[P2_POS] = ^(message & P2_MASK);
    code[P4_POS] = ^(message & P4_MASK);
  end

endmodule

// File: rtl/hamming_encoder.sv
// Registered Hamming(7,4) encoder with valid/ready on both sides and one output stage.
// A new word can load in the same cycle the held word is consumed.
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] message,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  codeword
);

  logic            out_valid_d, out_valid_q;
  logic [CW_W-1:0] codeword_d, codeword_q;
  logic [CW_W-1:0] encoded;
  logic            accept;

  hamming74_parity u_parity (
    .message (message),
    .code    (encoded)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    codeword_d  = codeword_q;
    if (accept) begin
      out_valid_d = 1'b1;
      codeword_d  = encoded;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      codeword_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      codeword_q  <= codeword_d;
    end
  end

  assign out_valid = out_valid_q;
  assign codeword  = codeword_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Self-checking bench for hamming_encoder: positional Hamming model, handshake model,
// in-order scoreboard, single-bit syndrome property and directed literal spot checks.
module tb_hamming_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] message = 4'b0000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] codeword;

  int n_cmp = 0;
  int n_bad = 0;

  hamming_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .message   (message),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeword  (codeword)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Positional Hamming rule: data fills the non-power-of-two positions in order,
  // parity at position 2^k covers every other position whose index has bit k set.
  function automatic logic [6:0] model_enc(input logic [3:0] m);
    logic [6:0] w;
    logic       p;
    int         di;
    w  = '0;
    di = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos-1] = m[di];
        di++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++) begin
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p ^= w[pos-1];
      end
      w[(1 << k) - 1] = p;
    end
    return w;
  endfunction

  function automatic int syndrome(input logic [6:0] w);
    int s;
    s = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      if (w[pos-1]) s ^= pos;
    end
    return s;
  endfunction

  // Handshake model: one output slot plus an in-order scoreboard of accepted words.
  logic       m_valid = 1'b0;
  logic [6:0] m_word  = '0;
  logic [6:0] sb_q[$];
  wire        m_ready = !m_valid || out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_word  <= '0;
      sb_q.delete();
    end else begin
      if (m_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(codeword), 32'hdead);
        end else begin
          check("sb_order", 32'(codeword), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && m_ready) begin
        m_valid <= 1'b1;
        m_word  <= model_enc(message);
        sb_q.push_back(model_enc(message));
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Cycle compare on the falling edge, away from the active edge.
  logic [6:0] flipped;
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("in_ready", 32'(in_ready), 32'(m_ready));
    if (m_valid) begin
      check("codeword", 32'(codeword), 32'(m_word));
      check("syndrome0", 32'(syndrome(codeword)), 32'd0);
      for (int b = 0; b < 7; b++) begin
        flipped = codeword;
        flipped[b] = ~flipped[b];
        check("syndrome_flip", 32'(syndrome(flipped)), 32'(b + 1));
      end
    end
  end

  // Apply inputs, let one rising edge pass, return 1ns after it.
  task automatic drive(input logic v, input logic [3:0] m, input logic r);
    in_valid  = v;
    message   = m;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] spot;

    // Reset held with in_valid asserted.
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    message  = 4'b0101;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_codeword", 32'(codeword), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 4'b0101, 1'b1);
    check("first_accept_valid", 32'(out_valid), 32'd1);
    check("first_accept_word", 32'(codeword), 32'b0101101);
    drive(1'b0, 4'b0000, 1'b1);

    // Exhaustive back-to-back sweep with literal spot values.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 1'b1);
      check("sweep_valid", 32'(out_valid), 32'd1);
      spot = 7'bx;
      case (i)
        0:  spot = 7'b0000000;
        1:  spot = 7'b0000111;
        5:  spot = 7'b0101101;
        8:  spot = 7'b1001011;
        15: spot = 7'b1111111;
        default: ;
      endcase
      if (i == 0 || i == 1 || i == 5 || i == 8 || i == 15)
        check("sweep_spot", 32'(codeword), 32'(spot));
    end
    drive(1'b0, 4'b0000, 1'b1);

    // Backpressure: held word stays, no loss or duplication.
    drive(1'b1, 4'b0001, 1'b1);
    check("bp_first", 32'(codeword), 32'b0000111);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b1000, 1'b0);
      check("bp_hold_word", 32'(codeword), 32'b0000111);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    drive(1'b1, 4'b1000, 1'b1);
    check("bp_release_word", 32'(codeword), 32'b1001011);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 4'b0000, 1'b1);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("sb_empty_bp", 32'(sb_q.size()), 32'd0);

    // Drain: single word, out_valid pulses once, codeword retained.
    drive(1'b1, 4'b0101, 1'b1);
    check("drain_pulse", 32'(out_valid), 32'd1);
    drive(1'b0, 4'bxxxx, 1'b1);
    check("drain_cleared", 32'(out_valid), 32'd0);
    check("drain_retain", 32'(codeword), 32'b0101101);
    drive(1'b0, 4'bxxxx, 1'b1);
    check("drain_still_low", 32'(out_valid), 32'd0);
    check("drain_still_word", 32'(codeword), 32'b0101101);

    // Asynchronous reset between edges while a word is held.
    drive(1'b1, 4'b1111, 1'b0);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_word", 32'(codeword), 32'b1111111);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_word", 32'(codeword), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 4'b1000, 1'b1);
    check("post_ar_word", 32'(codeword), 32'b1001011);
    drive(1'b0, 4'b0000, 1'b1);
    check("sb_empty_end", 32'(sb_q.size()), 32'd0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
